// File: rtl/apb_master_fsm.sv
// ---------------------------------------------------------------------------
// apb_master_fsm
//
// APB requester that turns a single local command (valid/ready handshake)
// into one APB transfer (SETUP then ACCESS). When the transfer completes, it
// returns a one-cycle response pulse with the read data and an error flag.
// An optional wait-state timeout ends an ACCESS phase that the completer
// never finishes. A timed-out transfer is reported as an error with zero data.
//
// Parameters
//   ADDR_WIDTH  width of cmd_addr / paddr
//   DATA_WIDTH  width of all data buses
//   TIMEOUT     maximum ACCESS cycles before forced completion (0 = none)
//
// Ports
//   pclk, presetn                    clock, async active-low reset
//   cmd_valid, cmd_ready             local command handshake
//   cmd_write, cmd_addr, cmd_wdata   command payload
//   rsp_valid, rsp_rdata, rsp_err    one-cycle completion pulse and payload
//   psel, penable, pwrite            APB control
//   paddr, pwdata                    APB address / write data
//   prdata, pready, pslverr          APB completer response
// ---------------------------------------------------------------------------
module apb_master_fsm #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  // local command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // local response side
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB requester side
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // The counter width must hold TIMEOUT. A disabled timeout still needs a
  // legal one-bit vector.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             cmd_accept;
  logic             timeout_hit;

  assign cmd_accept = cmd_valid && cmd_ready;

  // The last allowed wait cycle ends the transfer unless pready arrives in
  // that same cycle. A real completion takes priority over the timeout.
  assign timeout_hit = (TIMEOUT > 0) && (state_q == ACCESS) && !pready &&
                       (wait_cnt_q == CNT_LAST);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state is always assigned with <= so that every register
  // samples the pre-edge value of every other register, whatever the order.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case statement. Without it, any
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State-decoded outputs. Because they are decoded straight from state_q,
  // reset clears them immediately.
  // -------------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    unique case (state_q)
      IDLE:    cmd_ready = 1'b1;
      SETUP:   psel      = 1'b1;
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // APB request registers. They load only when a command is accepted, so the
  // address and data stay stable through SETUP and ACCESS and keep their
  // value in IDLE.
  // -------------------------------------------------------------------------
  // NOTE: these are plain data registers, not a memory. Resetting them costs
  // little and gives a defined bus value straight out of reset.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (cmd_accept) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Wait-state counter. It clears during SETUP, so it starts at zero on
  // entry to ACCESS. It counts ACCESS cycles without pready and saturates
  // instead of wrapping.
  // -------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ACCESS) && !pready && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Response registers. rsp_valid is a single-cycle pulse raised by the edge
  // that leaves ACCESS. The payload holds its value until the next completion.
  // -------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state_q == ACCESS) begin
        if (pready) begin
          rsp_valid <= 1'b1;
          rsp_err   <= pslverr;
          // Writes return zero so no stale bus data leaks into the response.
          rsp_rdata <= pwrite ? '0 : prdata;
        end else if (timeout_hit) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
    end
  end

endmodule
